instr_sequencer: RTL
====================

# instr_sequencer

Program buffer and instruction issuer that feeds the fetch stage of the control unit, which sits at the other end of this interface. Accepts 8-bit instruction words from a loader (switches plus strobe) into a small program memory. On command, streams the stored words to the control unit over a valid/ready handshake. Supports a HALT word, optional looping and abort, so the core can execute a stored program instead of one switch setting per fetch.

## Interface
- DEPTH, 16, number of program slots; power of two, at least 2
- IW, 8, instruction width: mode[7], opcode[6:4], regA[3:2], regB[1:0]
- AW, $clog2(DEPTH), program-counter width

Ports:
- clock_pulse  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock_pulse
- load_valid  in  1  loader presents load_data
- load_data  in  IW  instruction word to append
- load_ready  out  1  buffer can accept a word
- run  in  1  start or restart issue from slot 0
- stop  in  1  end issue early
- clear  in  1  empty the program and return to IDLE
- loop_en  in  1  wrap to slot 0 after the last slot instead of finishing
- instr_valid  out  1  instr_data holds an instruction for the core
- instr_data  out  IW  instruction word for the core
- instr_ready  in  1  core accepts instr_data this cycle (its fetch state)
- pc  out  AW  slot currently presented
- count  out  AW+1  number of loaded words, 0..DEPTH
- busy  out  1  state is RUN
- done  out  1  state is DONE

## Operation
- States: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The encoding 2'b11 is illegal and returns to IDLE on the next edge.
- HALT word is 8'h00 (mode 0, opcode 000).
- A transfer occurs in a cycle when instr_valid && instr_ready.

IDLE:
- load_ready = (count < DEPTH).
- load_valid && load_ready: writes mem[count] and increments count.
- When full (count == DEPTH), load_ready = 0 and load_valid is ignored; memory and count are unchanged.
- run with count > 0: pc <= 0, go to RUN.
- run with count == 0: ignored, stay in IDLE.
- clear: count <= 0, pc <= 0.
- Priority: clear > run > load.

RUN:
- load_ready = 0.
- instr_data = mem[pc].
- instr_valid = (mem[pc] != HALT).
- mem[pc] == HALT: no transfer; go to DONE next edge with pc unchanged.
- On a transfer with pc < count-1: pc <= pc+1.
- On a transfer with pc == count-1: if loop_en, pc <= 0 and stay in RUN; otherwise go to DONE with pc unchanged.
- instr_data and pc stay stable while instr_valid && !instr_ready.
- stop: go to DONE. A transfer in the same cycle completes normally and pc advances or wraps as above.
- clear: abort to IDLE, count <= 0, pc <= 0. clear beats stop, and beats any transfer in the same cycle (pc does not advance; the word is considered consumed by the core).

DONE:
- instr_valid = 0, load_ready = 0.
- run: pc <= 0, go to RUN; the program is preserved.
- clear: go to IDLE, count <= 0, pc <= 0. clear beats run.

Other rules:
- The outputs busy and done decode directly from state.
- count saturates at DEPTH; pc never exceeds count-1 while in RUN.
- Memory contents are not reset and not cleared. Slots at or above count are never presented.

## Timing
- Reset values: state IDLE, count 0, pc 0, instr_valid 0, busy 0, done 0, load_ready 1. instr_data is don't-care while instr_valid = 0 and is driven 0 in IDLE.
- Reset applied mid-RUN takes effect at that edge: instr_valid drops in the next cycle and the program length is lost.
- Load: one word per cycle at full rate. A word written at edge k is readable from cycle k+1.
- Issue latency: run sampled at edge k puts the machine in RUN after k, so instr_valid is first high in cycle k+1.
- Throughput: one transfer per cycle while instr_ready is held high.
- HALT: detected in the cycle mem[pc] is presented; DONE is entered one edge later.
- instr_valid and instr_data are combinational from state, pc and memory. They never depend combinationally on instr_ready.

## Structure
- Shared package holds:
  - the state encoding;
  - HALT = 8'h00;
  - ISA field positions (MODE_BIT = 7, OPC = [6:4], RA = [3:2], RB = [1:0]);
  - opcodes ADD = 3'b001 and INC = 3'b011, shared with the control unit.
- Sub-module prog_mem: DEPTH x IW register array with one synchronous write port and one asynchronous read port, no reset.
- Top level holds the FSM, pc, count and handshake logic.

## Test plan
- Load 8'h91, 8'hB0, 8'h95; pulse run; hold instr_ready = 1. Required: transfers 91, B0, 95 in cycles 1-3 after run; done = 1 in cycle 4; pc = 2.
- Same program with instr_ready toggling 1,0,0,1,1. Required: B0 held stable with pc = 1 across the stall cycles; exactly 3 transfers, no duplicates.
- Load 8'h91, 8'h00, 8'hB0; run. Required: one transfer (91), then instr_valid = 0 with pc = 1; DONE one edge later; B0 never presented.
- Load 2 words with loop_en = 1 and instr_ready = 1 for 6 cycles, then stop. Required: sequence 91, B0, 91, B0, ...; stop with a concurrent transfer advances pc, then DONE.
- Load 17 words with load_valid held. Required: count = 16, load_ready = 0 after the 16th; the 17th is dropped; mem[0..15] intact.
- In RUN mid-program, assert clear together with stop and a transfer. Required: IDLE next, count = 0, pc = 0, done = 0. In a separate run, reset asserted mid-RUN gives all reset values the next cycle.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the program sequencer and the control unit it feeds:
// FSM encoding, HALT word, ISA field layout and the opcodes both sides agree on.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [7:0] HALT     = 8'h00;
  localparam int         MODE_BIT = 7;
  localparam int         OPC_HI   = 6;
  localparam int         OPC_LO   = 4;
  localparam int         RA_HI    = 3;
  localparam int         RA_LO    = 2;
  localparam int         RB_HI    = 1;
  localparam int         RB_LO    = 0;

  localparam logic [2:0] OPC_ADD  = 3'b001;
  localparam logic [2:0] OPC_INC  = 3'b011;

  // Assemble an instruction word from its fields.
  function automatic logic [7:0] make_instr(input logic       mode,
                                            input logic [2:0] opc,
                                            input logic [1:0] ra,
                                            input logic [1:0] rb);
    logic [7:0] w;
    w                = 8'h00;
    w[MODE_BIT]      = mode;
    w[OPC_HI:OPC_LO] = opc;
    w[RA_HI:RA_LO]   = ra;
    w[RB_HI:RB_LO]   = rb;
    return w;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x IW register array, one synchronous write port and one
// asynchronous read port. Deliberately not reset; the sequencer tracks validity.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program buffer and issuer: appends loader words into prog_mem, then streams
// them to the control unit over valid/ready with HALT, loop, stop and clear.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock_pulse,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  output logic          load_ready,
  input  logic          run,
  input  logic          stop,
  input  logic          clear,
  input  logic          loop_en,
  output logic          instr_valid,
  output logic [IW-1:0] instr_data,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PC  = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_we_s;
  logic [IW-1:0] rd_data_s;
  logic          in_run_s;
  logic          halt_s;
  logic          xfer_s;
  logic          last_s;
  logic          end_s;

  prog_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_prog_mem (
    .clk   (clock_pulse),
    .we    (mem_we_s),
    .waddr (count_q[AW-1:0]),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (rd_data_s)
  );

  assign in_run_s    = (state_q == ST_RUN);
  assign halt_s      = (rd_data_s == IW'(HALT));
  assign instr_valid = in_run_s && !halt_s;
  assign instr_data  = in_run_s ? rd_data_s : '0;
  assign xfer_s      = instr_valid && instr_ready;
  assign last_s      = ({1'b0, pc_q} == (count_q - ONE_CNT));
  assign end_s       = xfer_s && last_s && !loop_en;
  assign load_ready  = (state_q == ST_IDLE) && (count_q < DEPTH_CNT);
  assign pc          = pc_q;
  assign count       = count_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

  // Next-state, pc, count and memory write decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
          pc_d    = '0;
        end else if (run && (count_q != '0)) begin
          pc_d    = '0;
          state_d = ST_RUN;
        end else if (load_valid && load_ready) begin
          mem_we_s = 1'b1;
          count_d  = count_q + ONE_CNT;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          // Any same-cycle transfer is treated as consumed; pc does not move.
          state_d = ST_IDLE;
          count_d = '0;
          pc_d    = '0;
        end else begin
          if (xfer_s && !last_s) begin
            pc_d = pc_q + ONE_PC;
          end else if (xfer_s && loop_en) begin
            pc_d = '0;
          end else begin
            pc_d = pc_q;
          end
          state_d = (halt_s || stop || end_s) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          pc_d    = '0;
        end else if (run) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

endmodule
